// File: rtl/cpu_dbus_arbiter_pkg.sv
// Shared types for the CPU data-bus arbiter: FSM state, one-hot grant and the latched request.
// Build option DBUS_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (see cpu_dbus_arb_pick).
package cpu_dbus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_M0 = 2'd1,
        BUSY_M1 = 2'd2
    } DbusArbState_t;

    typedef logic [1:0] DbusGrant_t;

    localparam DbusGrant_t GRANT_NONE = 2'b00;
    localparam DbusGrant_t GRANT_M0   = 2'b01;
    localparam DbusGrant_t GRANT_M1   = 2'b10;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data_wr;
        logic [3:0]  mask;
        logic        read;
        logic        write;
    } dbus_req_t;

    localparam dbus_req_t REQ_NONE = '0;

    function automatic logic is_req(input dbus_req_t r);
        return r.read | r.write;
    endfunction

endpackage

// File: rtl/bus_if.sv
// CPU data-bus interface shared by the MEM stage, secondary masters and the downstream bridge.
interface Bus_if;
    logic [31:0] address;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic [3:0]  mask;
    logic        read;
    logic        write;
    logic        stall;

    modport master (
        output address, data_wr, mask, read, write,
        input  data_rd, stall
    );

    modport slave (
        input  address, data_wr, mask, read, write,
        output data_rd, stall
    );
endinterface

// File: rtl/cpu_dbus_arb_pick.sv
// Combinational winner select for the data-bus arbiter.
// DBUS_ARB_ROUND_ROBIN_EN: ties go to the master not granted last; otherwise m0 always wins.
module cpu_dbus_arb_pick
    import cpu_dbus_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_m1,
    output DbusGrant_t grant
);

`ifdef DBUS_ARB_ROUND_ROBIN_EN
    // NOTE: default first so every path assigns grant and no latch is inferred.
    always_comb begin
        grant = GRANT_NONE;
        if (req0 && req1) begin
            grant = last_m1 ? GRANT_M0 : GRANT_M1;
        end else if (req0) begin
            grant = GRANT_M0;
        end else if (req1) begin
            grant = GRANT_M1;
        end
    end
`else
    // Fixed priority: the history bit has no effect and its flop is pruned upstream.
    logic unused_last_m1;
    assign unused_last_m1 = last_m1;

    always_comb begin
        grant = GRANT_NONE;
        if (req0) begin
            grant = GRANT_M0;
        end else if (req1) begin
            grant = GRANT_M1;
        end
    end
`endif

endmodule

// File: rtl/cpu_dbus_arbiter.sv
// Two-master, one-slave CPU data-bus arbiter with zero-latency grant and a held request while stalled.
// Tie policy is set by DBUS_ARB_ROUND_ROBIN_EN inside cpu_dbus_arb_pick.
module cpu_dbus_arbiter
    import cpu_dbus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    Bus_if.slave       m0,
    Bus_if.slave       m1,
    Bus_if.master      s,
    output DbusGrant_t grant
);

    DbusArbState_t state;
    dbus_req_t     req_q;
    dbus_req_t     req0;
    dbus_req_t     req1;
    dbus_req_t     fwd;
    DbusGrant_t    pick;
    DbusGrant_t    owner;
    logic          last_m1;
    logic          done;

    assign req0 = {m0.address, m0.data_wr, m0.mask, m0.read, m0.write};
    assign req1 = {m1.address, m1.data_wr, m1.mask, m1.read, m1.write};

    cpu_dbus_arb_pick u_pick (
        .req0    (is_req(req0)),
        .req1    (is_req(req1)),
        .last_m1 (last_m1),
        .grant   (pick)
    );

    // Outputs are gated by rst_n so a request held during reset never reaches the slave.
    always_comb begin
        owner = GRANT_NONE;
        fwd   = REQ_NONE;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    owner = pick;
                    if (pick == GRANT_M0) begin
                        fwd = req0;
                    end else if (pick == GRANT_M1) begin
                        fwd = req1;
                    end
                end
                BUSY_M0: begin
                    owner = GRANT_M0;
                    fwd   = req_q;
                end
                BUSY_M1: begin
                    owner = GRANT_M1;
                    fwd   = req_q;
                end
                default: ;
            endcase
        end
    end

    assign s.address = fwd.address;
    assign s.data_wr = fwd.data_wr;
    assign s.mask    = fwd.mask;
    assign s.read    = fwd.read;
    assign s.write   = fwd.write;
    assign grant     = owner;

    // Owner sees the slave stall, a waiting non-owner is held off, an idle master is left alone.
    assign m0.stall   = rst_n & (owner[0] ? s.stall : is_req(req0));
    assign m1.stall   = rst_n & (owner[1] ? s.stall : is_req(req1));
    assign m0.data_rd = owner[0] ? s.data_rd : 32'h0;
    assign m1.data_rd = owner[1] ? s.data_rd : 32'h0;

    assign done = is_req(fwd) & ~s.stall;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= REQ_NONE;
            last_m1 <= 1'b1;
        end else begin
            if (done) begin
                last_m1 <= owner[1];
            end
            case (state)
                IDLE: begin
                    if (owner != GRANT_NONE) begin
                        req_q <= fwd;
                        if (s.stall) begin
                            state <= owner[1] ? BUSY_M1 : BUSY_M0;
                        end
                    end
                end
                BUSY_M0, BUSY_M1: begin
                    if (!s.stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_dbus_arbiter.sv
// Directed self-checking bench for cpu_dbus_arbiter; tie expectations follow DBUS_ARB_ROUND_ROBIN_EN.
module tb_cpu_dbus_arbiter;
    import cpu_dbus_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    DbusGrant_t grant;
    int         checks;
    int         errors;

    Bus_if m0_bus ();
    Bus_if m1_bus ();
    Bus_if s_bus ();

    cpu_dbus_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_m0(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] msk);
        m0_bus.read    = rd;
        m0_bus.write   = wr;
        m0_bus.address = addr;
        m0_bus.data_wr = wdata;
        m0_bus.mask    = msk;
    endtask

    task automatic drive_m1(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] msk);
        m1_bus.read    = rd;
        m1_bus.write   = wr;
        m1_bus.address = addr;
        m1_bus.data_wr = wdata;
        m1_bus.mask    = msk;
    endtask

    task automatic slave_resp(input logic stl, input logic [31:0] rdata);
        s_bus.stall   = stl;
        s_bus.data_rd = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_grant;
        checks = 0;
        errors = 0;

        // Reset with a live request: nothing may leak to the slave or the masters.
        rst_n = 1'b0;
        drive_m0(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slave_resp(1'b0, 32'h0);
        #3;
        check("rst_s_read", s_bus.read, 1'b0);
        check("rst_s_write", s_bus.write, 1'b0);
        check("rst_s_addr", s_bus.address, 32'h0);
        check("rst_s_mask", s_bus.mask, 4'h0);
        check("rst_grant", grant, 2'b00);
        check("rst_m0_stall", m0_bus.stall, 1'b0);
        check("rst_m1_stall", m1_bus.stall, 1'b0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Single m0 read, zero-wait.
        drive_m0(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
        slave_resp(1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        check("rd_s_read", s_bus.read, 1'b1);
        check("rd_s_addr", s_bus.address, 32'h8000_0010);
        check("rd_m0_data", m0_bus.data_rd, 32'hDEAD_BEEF);
        check("rd_m1_data", m1_bus.data_rd, 32'h0);
        check("rd_m0_stall", m0_bus.stall, 1'b0);
        check("rd_grant", grant, 2'b01);
        next_cycle();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("rd_idle_grant", grant, 2'b00);
        check("rd_idle_s_read", s_bus.read, 1'b0);
        next_cycle();

        // m0 write with a 3-cycle slave stall; m1 arrives during BUSY and must wait.
        drive_m0(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
        for (int c = 0; c < 4; c++) begin
            slave_resp(c < 3, 32'h0);
            if (c == 1) drive_m1(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
            @(negedge clk);
            check($sformatf("wr_s_write_%0d", c), s_bus.write, 1'b1);
            check($sformatf("wr_s_read_%0d", c), s_bus.read, 1'b0);
            check($sformatf("wr_s_addr_%0d", c), s_bus.address, 32'h0000_0100);
            check($sformatf("wr_s_data_%0d", c), s_bus.data_wr, 32'h1234_5678);
            check($sformatf("wr_s_mask_%0d", c), s_bus.mask, 4'b0011);
            check($sformatf("wr_m0_stall_%0d", c), m0_bus.stall, (c < 3) ? 1'b1 : 1'b0);
            check($sformatf("wr_grant_%0d", c), grant, 2'b01);
            if (c >= 1) check($sformatf("wr_m1_stall_%0d", c), m1_bus.stall, 1'b1);
            next_cycle();
        end
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slave_resp(1'b0, 32'hCAFE_0001);
        @(negedge clk);
        check("wr_m1_grant", grant, 2'b10);
        check("wr_m1_addr", s_bus.address, 32'h0000_0200);
        check("wr_m1_stall", m1_bus.stall, 1'b0);
        check("wr_m1_data", m1_bus.data_rd, 32'hCAFE_0001);
        check("wr_m0_data", m0_bus.data_rd, 32'h0);
        next_cycle();

        // Both masters request every cycle, zero-wait; last completion was m1.
        drive_m0(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
        slave_resp(1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
`ifdef DBUS_ARB_ROUND_ROBIN_EN
            exp_grant = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b01;
`endif
            @(negedge clk);
            check($sformatf("tie_grant_%0d", c), grant, exp_grant);
            check($sformatf("tie_addr_%0d", c), s_bus.address,
                  exp_grant[0] ? 32'h0000_1000 : 32'h0000_2000);
            check($sformatf("tie_m0_stall_%0d", c), m0_bus.stall, exp_grant[1]);
            check($sformatf("tie_m1_stall_%0d", c), m1_bus.stall, exp_grant[0]);
            next_cycle();
        end

        // Read+write together with an empty mask goes through untouched.
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b1, 32'h0000_6000, 32'hA5A5_A5A5, 4'b0000);
        @(negedge clk);
        check("rw_s_read", s_bus.read, 1'b1);
        check("rw_s_write", s_bus.write, 1'b1);
        check("rw_s_mask", s_bus.mask, 4'b0000);
        check("rw_s_data", s_bus.data_wr, 32'hA5A5_A5A5);
        check("rw_grant", grant, 2'b10);
        next_cycle();

        // m1 read granted, flushed during BUSY; latched request must run to completion.
        drive_m1(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
        slave_resp(1'b1, 32'h0);
        @(negedge clk);
        check("ab_grant_0", grant, 2'b10);
        check("ab_m1_stall_0", m1_bus.stall, 1'b1);
        next_cycle();
        drive_m1(1'b0, 1'b0, 32'h0000_3FFF, 32'h0, 4'h0);
        drive_m0(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
        @(negedge clk);
        check("ab_s_read_1", s_bus.read, 1'b1);
        check("ab_s_addr_1", s_bus.address, 32'h0000_3000);
        check("ab_grant_1", grant, 2'b10);
        check("ab_m0_stall_1", m0_bus.stall, 1'b1);
        next_cycle();
        slave_resp(1'b0, 32'h7777_0000);
        @(negedge clk);
        check("ab_s_read_2", s_bus.read, 1'b1);
        check("ab_s_addr_2", s_bus.address, 32'h0000_3000);
        check("ab_m1_data_2", m1_bus.data_rd, 32'h7777_0000);
        check("ab_m0_stall_2", m0_bus.stall, 1'b1);
        next_cycle();
        @(negedge clk);
        check("ab_idle_grant", grant, 2'b01);
        check("ab_idle_addr", s_bus.address, 32'h0000_4000);
        next_cycle();

        // Asynchronous reset while BUSY_M0 with both masters still requesting.
        drive_m0(1'b0, 1'b1, 32'h0000_5000, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h0000_5100, 32'h0, 4'hF);
        slave_resp(1'b1, 32'h0);
        @(negedge clk);
        check("rb_grant_0", grant, 2'b01);
        next_cycle();
        @(negedge clk);
        check("rb_busy_addr", s_bus.address, 32'h0000_5000);
        #1;
        rst_n = 1'b0;
        #1;
        check("rb_s_read", s_bus.read, 1'b0);
        check("rb_s_write", s_bus.write, 1'b0);
        check("rb_grant", grant, 2'b00);
        check("rb_m0_stall", m0_bus.stall, 1'b0);
        check("rb_m1_stall", m1_bus.stall, 1'b0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slave_resp(1'b0, 32'h0);
        next_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        drive_m0(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
        @(negedge clk);
        check("rb_tie_grant_0", grant, 2'b01);
        next_cycle();
`ifdef DBUS_ARB_ROUND_ROBIN_EN
        exp_grant = 2'b10;
`else
        exp_grant = 2'b01;
`endif
        @(negedge clk);
        check("rb_tie_grant_1", grant, exp_grant);
        next_cycle();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
